// File: rtl/fb_scan_fetcher.sv
// Purpose : walk an IMG_W x IMG_H image in video RAM from a latched scroll base and
//           stream its pixels to the HDMI pixel pipeline, replicated SCALE x SCALE.
// Latency : first pix_valid RD_LAT+3 cycles after frame_start (never earlier than RD_LAT+1).
// Backpr. : pix_ready low holds the head pixel; reads stop once FIFO + in-flight words fill FIFO_DEPTH.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   frame_start, base_addr       one-cycle (re)start pulse, scroll base sampled with it
//   mem_addr, mem_rd, mem_rdata  fixed-latency video RAM read port (data RD_LAT cycles after mem_rd)
//   pix_valid, pix_ready, pix_data  24-bit RGB output stream
//   frame_busy, underflow        frame in progress, sticky starvation flag (cleared by frame_start)
// Optional feature: define RGB332_EXPAND_EN to expand 8-bit RGB332 words to RGB888;
//   otherwise each word is shown as grayscale.
module fb_scan_fetcher #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int SCALE      = 1,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic              frame_busy,
    output logic              underflow
);
    localparam int CW          = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW          = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW          = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam int NW          = PW + 3;
    localparam int TOTAL_WORDS = IMG_W * IMG_H * SCALE;
    localparam int OW          = $clog2(TOTAL_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] line_addr;    // base + row*IMG_W, advanced once per source line
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [SW-1:0]     rep_y;        // vertical repeat of the current source line
    logic [SW-1:0]     rep_x;        // accepted beats of the current head word
    logic [RD_LAT-1:0] vld_pipe;     // one bit per read in flight, tail = data arrives now
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       fifo_cnt;
    logic [OW-1:0]     pop_cnt;
    logic [NW-1:0]     pending;
    logic [DATA_W-1:0] head;
    logic [23:0]       pix_rgb;
    logic              push, pop, accept, credit_ok;
    logic              last_col, last_rep_y, last_row, last_rep_x, last_pop;

    assign head       = fifo_mem[rd_ptr];
    assign pix_valid  = (fifo_cnt != '0);
    assign accept     = pix_valid & pix_ready;
    assign last_rep_x = (rep_x == SW'(SCALE - 1));
    assign pop        = accept & last_rep_x;
    assign push       = vld_pipe[RD_LAT-1];
    assign last_pop   = pop & (pop_cnt == OW'(TOTAL_WORDS - 1));
    assign last_col   = (col == CW'(IMG_W - 1));
    assign last_rep_y = (rep_y == SW'(SCALE - 1));
    assign last_row   = (row == RW'(IMG_H - 1));

    // Words already stored, the read on the bus now, and reads still in the
    // pipe all hold a FIFO slot; a new read is allowed only if one is left.
    always_comb begin
        pending = NW'(fifo_cnt) + NW'(mem_rd);
        for (int i = 0; i < RD_LAT; i++) begin
            pending = pending + NW'(vld_pipe[i]);
        end
    end
    assign credit_ok = (pending < NW'(FIFO_DEPTH));

`ifdef RGB332_EXPAND_EN
    assign pix_rgb = {head[7:5], head[7:5], head[7:6],
                      head[4:2], head[4:2], head[4:3],
                      {4{head[1:0]}}};
`else
    logic [7:0] gray;
    if (DATA_W >= 8) begin : g_gray_msb
        assign gray = head[DATA_W-1 -: 8];
    end else begin : g_gray_pad
        assign gray = {head, {(8 - DATA_W){1'b0}}};
    end
    assign pix_rgb = {3{gray}};
`endif

    // Storage is only read when fifo_cnt says the slot is valid, so it needs no reset.
    assign pix_data = pix_valid ? pix_rgb : 24'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            line_addr  <= '0;
            col        <= '0;
            row        <= '0;
            rep_y      <= '0;
            rep_x      <= '0;
            vld_pipe   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            pop_cnt    <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            frame_busy <= 1'b0;
            underflow  <= 1'b0;
        end else if (frame_start) begin
            // Start or abort: dropping the in-flight bits discards any stale returns.
            state      <= S_FETCH;
            line_addr  <= base_addr;
            col        <= '0;
            row        <= '0;
            rep_y      <= '0;
            rep_x      <= '0;
            vld_pipe   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            pop_cnt    <= '0;
            mem_rd     <= 1'b0;
            frame_busy <= 1'b1;
            underflow  <= 1'b0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            vld_pipe[0] <= mem_rd;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase

            if (accept) rep_x <= last_rep_x ? '0 : rep_x + 1'b1;
            if (pop)    pop_cnt <= pop_cnt + 1'b1;

            if (frame_busy && pix_ready && !pix_valid) underflow <= 1'b1;

            mem_rd <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (credit_ok) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= line_addr + ADDR_W'(col);
                        if (last_col) begin
                            col <= '0;
                            if (last_rep_y) begin
                                rep_y     <= '0;
                                line_addr <= line_addr + ADDR_W'(IMG_W);
                                if (last_row) state <= S_DRAIN;
                                else          row   <= row + 1'b1;
                            end else begin
                                rep_y <= rep_y + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state      <= S_IDLE;
                        frame_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fb_scan_fetcher.md
Name: fb_scan_fetcher

Overview:
Parametrised successor to the fixed offset/address path between processor video memory and the HDMI transmitter. Per frame it walks a rectangular image in video RAM starting at a latched scroll base. It issues fixed-latency reads and buffers returned pixels in a small FIFO. Pixels go to the HDMI pixel pipeline over a valid/ready stream, with integer up-scaling.

Parameters:
ADDR_W, 18, video RAM address width
DATA_W, 8, video RAM word (pixel) width; max 24
IMG_W, 256, source pixels per line
IMG_H, 256, source lines per frame
SCALE, 1, integer replication factor in both axes (1..8)
RD_LAT, 2, cycles from mem_rd to mem_rdata valid (1..4)
FIFO_DEPTH, 8, pixel FIFO entries; power of two, >= RD_LAT+2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse; latch base, (re)start frame
base_addr  in  ADDR_W  scroll offset, sampled on frame_start
mem_addr  out  ADDR_W  read address to video RAM
mem_rd  out  1  read strobe, one cycle per word
mem_rdata  in  DATA_W  read data, valid exactly RD_LAT cycles after mem_rd
pix_valid  out  1  pix_data valid
pix_ready  in  1  consumer accepts when pix_valid & pix_ready
pix_data  out  24  RGB pixel to HDMI_TX_D path
frame_busy  out  1  high from frame_start until last pixel accepted
underflow  out  1  sticky: pix_ready high, pix_valid low while frame_busy; cleared by frame_start

Behaviour:
- Reset values: mem_addr=0, mem_rd=0, pix_valid=0, pix_data=0, frame_busy=0, underflow=0. FIFO empty, in-flight pipe cleared, state IDLE.
- States: IDLE -> FETCH on frame_start. FETCH -> DRAIN after last read is issued. DRAIN -> IDLE when last output pixel is accepted.
- Fetch order: row r (0..IMG_H-1), each line repeated SCALE times; col c (0..IMG_W-1).
- mem_addr = base + r*IMG_W + c, truncated mod 2^ADDR_W. Wrap-around at the top of memory is legal and silent.
- Credit rule: mem_rd asserted only when FIFO occupancy + in-flight < FIFO_DEPTH. Overflow is therefore impossible.
- In-flight tracking: RD_LAT-deep valid shift register. A word is written to the FIFO when the tail bit is set.
- Output: head word held for SCALE accepted beats, then popped. pix_valid = FIFO non-empty.
- Simultaneous push/pop on the same cycle: occupancy unchanged. A push to an empty FIFO is visible on pix_valid the next cycle.
- Latency: first pix_valid no earlier than RD_LAT+1 cycles after frame_start.
- Total beats per frame: IMG_W*SCALE*IMG_H*SCALE exactly. frame_busy falls the cycle after the final handshake.
- frame_start in FETCH/DRAIN (abort): same cycle it flushes the FIFO and clears the in-flight pipe, so stale returns are discarded. It also resets counters, latches the new base, and clears underflow. Fetching restarts next cycle.
- pix_ready while !frame_busy: ignored. pix_valid stays 0.
- rst_n low mid-frame: immediate return to reset values. No read strobe is generated while rst_n is low.

Optional Feature:
RGB332_EXPAND_EN
- Defined (needs DATA_W=8): pix_data = {R3,R3,R3[2:1], G3,G3,G3[2:1], B2,B2,B2,B2}. R3=w[7:5], G3=w[4:2], B2=w[1:0].
- Undefined: grayscale. pix_data = {3{w zero/MSB-aligned to 8 bits}}; for DATA_W=8 this is {w,w,w}.

Test Plan:
1. IMG_W=4, IMG_H=2, SCALE=1, base=0x100, pix_ready=1, memory returns addr[7:0]. Expected: 8 beats carrying 00..07, mem_addr 0x100..0x107, frame_busy high for exactly that frame.
2. SCALE=2, same image. Expected: 32 beats; line 0 reads 0x100..0x103 twice; each pixel repeated 2 consecutive beats.
3. base=0x3FFFE, ADDR_W=18, IMG_W=4. Expected: mem_addr sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
4. pix_ready=0 for 50 cycles after frame_start. Expected: exactly FIFO_DEPTH reads issued, then mem_rd stays 0 and no data is lost; after ready rises, the full sequence is in order.
5. Second frame_start with 2 reads in flight, new base=0x200. Expected: old returns discarded; first accepted beat = data@0x200; underflow=0.
6. RGB332_EXPAND_EN with word 0xE3. Expected: pix_data=0xFF00FF. Without the macro: 0xE3E3E3.
